reg_bank: RTL and testbench

//  ZAFx32 general-purpose register bank. This is the consumer end of the write-register-select path.
//  - Receives the selected write index (rt / rd / r31 for jal, or 0 when unused) together with write-back data.
//  - Serves two combinational read ports (rs, rt) to decode.
//  - Keeps a per-register busy scoreboard, so decode can stall on a read-after-write hazard

---
 rtl/zaf_pkg.sv | 22 ++
 rtl/reg_scoreboard.sv | 65 ++++++
 rtl/reg_bank.sv | 79 +++++++
 tb/tb_reg_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/zaf_pkg.sv
// Shared ZAFx32 constants: datapath widths, architectural register indices
// and the write-register-select codes used upstream of the register bank.
package zaf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef enum logic [1:0] {
        WSEL_RT = 2'b00,
        WSEL_RD = 2'b01,
        WSEL_RA = 2'b10
    } wsel_t;

    // Index 0 is hardwired zero, so it is never a real write or issue target.
    function automatic logic is_live_idx(input logic [ADDR_W-1:0] idx);
        return idx != ADDR_W'(REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard for the ZAFx32 register bank: tracks in-flight
// producers, reports read-port hazards and keeps a count of pending registers.
module reg_scoreboard #(
    parameter int ADDR_W = zaf_pkg::ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);
    import zaf_pkg::*;

    logic [NREG-1:1] busy_q;
    logic [NREG-1:0] busy_v;
    logic [ADDR_W:0] pend_q;
    logic            iss_hit;
    logic            wr_hit;
    logic            cnt_inc;
    logic            cnt_dec;

    assign busy_v  = {busy_q, 1'b0};
    assign iss_hit = iss_en && (iss_dst != ADDR_W'(REG_ZERO));
    assign wr_hit  = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    // A write that lands on the register being re-issued this cycle clears
    // nothing: the newer producer keeps it busy, so neither count edge fires.
    assign cnt_inc = iss_hit && !busy_v[iss_dst];
    assign cnt_dec = wr_hit && busy_v[wr_addr] && !(iss_hit && (iss_dst == wr_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (iss_hit && (iss_dst == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_hit && (wr_addr == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_q <= pend_q + (ADDR_W+1)'(1);
                2'b01:   pend_q <= pend_q - (ADDR_W+1)'(1);
                default: pend_q <= pend_q;
            endcase
        end
    end

    // The value being written back this cycle is bypassed to decode, so it must not stall.
    assign busy_a   = busy_v[rd_addr_a] && !(wr_hit && (wr_addr == rd_addr_a));
    assign busy_b   = busy_v[rd_addr_b] && !(wr_hit && (wr_addr == rd_addr_b));
    assign stall    = busy_a || busy_b;
    assign pend_cnt = pend_q;

endmodule

// File: rtl/reg_bank.sv
// ZAFx32 general-purpose register bank: two combinational read ports with
// write-through bypass, one write-back port, and a busy scoreboard for decode.
module reg_bank #(
    parameter int DATA_W = zaf_pkg::DATA_W,
    parameter int ADDR_W = zaf_pkg::ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);
    import zaf_pkg::*;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    // Entry 0 is cleared by reset and never written, but reads of index 0 are
    // forced to zero in the mux regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == ADDR_W'(REG_ZERO)) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == ADDR_W'(REG_ZERO)) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_dst   (iss_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Directed, table-driven bench for reg_bank: reset, zero-index writes,
// bypass, scoreboard issue/clear, reset priority and pend_cnt range.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_dst;
    logic        busy_a, busy_b, stall;
    logic [5:0]  pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_bank dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_dst   (iss_dst),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  id;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
        logic [5:0]  ep;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] id,
                         input logic [4:0] ra, input logic [4:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_dst = id;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    // Inputs change just after a rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // row: we wa wd ie id ra rb | ea eb busy_a busy_b pend
        vt[0]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vt[2]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
        vt[4]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 5'd0,  5'd5,  5'd9,  32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 5'd9,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd9,  32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 6'd1};
        vt[7]  = '{1'b1, 5'd31, 32'h00400008, 1'b0, 5'd0,  5'd31, 5'd0,  32'h00400008, 32'h0,        1'b0, 1'b0, 6'd1};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd0,  32'h00400008, 32'h0,        1'b0, 1'b0, 6'd0};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vt[10] = '{1'b1, 5'd7,  32'h11112222, 1'b1, 5'd7,  5'd7,  5'd0,  32'h11112222, 32'h0,        1'b0, 1'b0, 6'd1};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h11112222, 32'h0,        1'b1, 1'b0, 6'd1};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd7,  5'd3,  32'h11112222, 32'h0,        1'b1, 1'b0, 6'd1};
        vt[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  5'd3,  32'h0,        32'h0,        1'b0, 1'b1, 6'd2};
        vt[14] = '{1'b1, 5'd4,  32'h00004444, 1'b0, 5'd0,  5'd4,  5'd3,  32'h00004444, 32'h0,        1'b0, 1'b1, 6'd2};
        vt[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd3,  32'h00004444, 32'h0,        1'b0, 1'b1, 6'd2};
        vt[16] = '{1'b1, 5'd7,  32'h77770000, 1'b1, 5'd4,  5'd7,  5'd4,  32'h77770000, 32'h00004444, 1'b0, 1'b0, 6'd2};
        vt[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd4,  32'h77770000, 32'h00004444, 1'b0, 1'b1, 6'd2};

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset state on every index of both ports (no clock needed, reads are combinational).
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk($sformatf("rst_data_a[%0d]", i), rd_data_a, 32'h0);
            chk($sformatf("rst_data_b[%0d]", 31 - i), rd_data_b, 32'h0);
            chk($sformatf("rst_busy[%0d]", i), {30'h0, busy_a, busy_b}, 32'h0);
        end
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_pend", {26'h0, pend_cnt}, 32'h0);

        for (int v = 0; v < NV; v++) begin
            drive(vt[v].we, vt[v].wa, vt[v].wd, vt[v].ie, vt[v].id, vt[v].ra, vt[v].rb);
            @(negedge clk);
            chk($sformatf("v%0d_data_a", v), rd_data_a, vt[v].ea);
            chk($sformatf("v%0d_data_b", v), rd_data_b, vt[v].eb);
            chk($sformatf("v%0d_busy_a", v), {31'h0, busy_a}, {31'h0, vt[v].eba});
            chk($sformatf("v%0d_busy_b", v), {31'h0, busy_b}, {31'h0, vt[v].ebb});
            chk($sformatf("v%0d_stall", v), {31'h0, stall}, {31'h0, vt[v].eba | vt[v].ebb});
            chk($sformatf("v%0d_pend", v), {26'h0, pend_cnt}, {26'h0, vt[v].ep});
            next_cycle();
        end

        // r3 and r4 busy, pend 2: reset must beat a simultaneous write and issue.
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'hFFFFFFFF, 1'b1, 5'd5, 5'd3, 5'd4);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5);
        @(negedge clk);
        chk("rstwin_r3", rd_data_a, 32'h0);
        chk("rstwin_r5", rd_data_b, 32'h0);
        chk("rstwin_busy", {30'h0, busy_a, busy_b}, 32'h0);
        chk("rstwin_pend", {26'h0, pend_cnt}, 32'h0);
        rd_addr_a = 5'd4;
        rd_addr_b = 5'd7;
        #1;
        chk("rstwin_r4_r7", {rd_data_a | rd_data_b}, 32'h0);
        chk("rstwin_busy47", {30'h0, busy_a, busy_b}, 32'h0);
        next_cycle();

        // Issue and write to a non-busy register in one cycle: it ends up busy.
        drive(1'b1, 5'd6, 32'h00006666, 1'b1, 5'd6, 5'd6, 5'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd0);
        @(negedge clk);
        chk("issw_busy6", {31'h0, busy_a}, 32'h1);
        chk("issw_data6", rd_data_a, 32'h00006666);
        chk("issw_pend", {26'h0, pend_cnt}, 32'h1);
        next_cycle();

        // Fill the scoreboard: pend_cnt tops out at NREG-1 and drains back to 0.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd0, 5'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);
        @(negedge clk);
        chk("full_pend", {26'h0, pend_cnt}, 32'd31);
        chk("full_busy", {30'h0, busy_a, busy_b}, 32'h3);
        chk("full_stall", {31'h0, stall}, 32'h1);
        next_cycle();
        for (int i = 31; i >= 1; i--) begin
            drive(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
            next_cycle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);
        @(negedge clk);
        chk("drain_pend", {26'h0, pend_cnt}, 32'h0);
        chk("drain_busy", {30'h0, busy_a, busy_b}, 32'h0);
        chk("drain_r1", rd_data_a, 32'd1);
        chk("drain_r31", rd_data_b, 32'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
